serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor that computes `a - b - bin` one bit per clock, LSB first. It drives a single full-subtractor cell (difference/borrow pair) and registers its borrow back into the cell's borrow input each cycle. It sits between an operand producer (valid/ready) and a result consumer (valid/ready). It trades WIDTH cycles of latency for one-bit datapath area.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  operands `a`, `b`, `bin` are valid.
- `in_ready`  output  1  block can accept operands.
- `a`  input  WIDTH  minuend, unsigned.
- `b`  input  WIDTH  subtrahend, unsigned.
- `bin`  input  1  borrow-in, applied at bit 0.
- `out_valid`  output  1  `diff`, `bout` and `ovf` hold a completed result.
- `out_ready`  input  1  consumer takes the result.
- `diff`  output  WIDTH  `(a - b - bin) mod 2^WIDTH`.
- `bout`  output  1  final borrow; 1 iff `a < b + bin` (unsigned).
- `ovf`  output  1  signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready` = 1.
  - On an edge with `in_valid & in_ready`:
    - latch `a` and `b` into shift registers.
    - load the borrow register with `bin`.
    - clear the bit counter to 0.
    - go to SHIFT.
- SHIFT:
  - The cell inputs are the current LSBs of the A/B shift registers plus the borrow register.
  - Cell bit: `d = a^b^c`.
  - Cell borrow: `bo = (~a & b) | (~(a^b) & c)`.
  - Each edge:
    - shift `d` into the MSB of the result register, right-shifting it.
    - right-shift the A and B registers.
    - borrow register ← `bo`.
    - counter += 1.
  - On the edge where counter == WIDTH-1, also capture `bo` into `bout` and go to DONE.
- DONE:
  - `out_valid` = 1.
  - `diff`, `bout` and `ovf` are held stable until `out_valid & out_ready` on an edge, then go to IDLE.
- `in_ready` = (state == IDLE) and is combinational from state. The block does not overlap operations.
- `in_valid` outside IDLE is ignored. Input operands need not be held after acceptance.
- The borrow register and counter are internal. The counter is ⌈log2 WIDTH⌉ bits wide and does not wrap during normal operation.

## Timing
- Reset (async, whenever `rst_n` = 0, including mid-SHIFT or in DONE):
  - state = IDLE.
  - `in_ready` = 1, `out_valid` = 0.
  - `diff` = 0, `bout` = 0, `ovf` = 0.
  - Shift registers, borrow register and counter are cleared. Any partial result is discarded.
- Acceptance on edge k: `out_valid` rises after edge k+WIDTH, which is a latency of WIDTH cycles.
- Throughput:
  - With `out_ready` held at 1, one result every WIDTH+2 cycles.
  - Sequence: accept, WIDTH shift edges, one DONE edge, return to IDLE for one cycle.
- DONE with `out_ready` = 1 already asserted: the handshake completes on the first DONE edge.
- Backpressure: DONE persists indefinitely with outputs frozen and `in_ready` = 0.
- `diff` is registered. It changes during SHIFT and is only meaningful while `out_valid` = 1.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - Port `ovf` exists.
  - `ovf = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1])`, using the latched MSBs.
  - `ovf` is registered and updated on the same edge as `bout`.
- `SERIAL_SUB_OVF_EN` undefined: port `ovf` and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH = 8.
- Basic: `a` = 0x5A, `b` = 0x3C, `bin` = 0 accepted on edge k → `out_valid` after edge k+8, `diff` = 0x1E, `bout` = 0.
- Underflow: `a` = 0x00, `b` = 0x01, `bin` = 0 → `diff` = 0xFF, `bout` = 1. Also `a` = 0x10, `b` = 0x10, `bin` = 1 → `diff` = 0xFF, `bout` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles after `out_valid` rises → `diff`/`bout` stable, `in_ready` = 0, and a new `in_valid` pulse is ignored. Raise `out_ready` → IDLE on the next edge.
- Reset mid-op: assert `rst_n` = 0 three cycles into SHIFT → immediately `out_valid` = 0, `diff` = 0, `in_ready` = 1. Then run `a` = 0xFF, `b` = 0x0F, `bin` = 0 → `diff` = 0xF0, `bout` = 0.
- Back-to-back: three operations with `in_valid` and `out_ready` tied to 1 → results spaced exactly 10 cycles apart, all values correct.
- Overflow (macro on): 0x80 − 0x01 → `diff` = 0x7F, `ovf` = 1. 0x7F − 0xFF → `diff` = 0x80, `ovf` = 1. 0x05 − 0x03 → `ovf` = 0.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for serial_subtractor
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
`ifdef SERIAL_SUB_OVF_EN
    , ovf
`endif
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
`ifdef SERIAL_SUB_OVF_EN
    , ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one full-subtractor cell
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave io
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_q;
  logic             borrow;
  logic             bout_q;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bo;
  logic             accept;
  logic             last_bit;

  assign cell_d   = a_sr[0] ^ b_sr[0] ^ borrow;
  assign cell_bo  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  assign accept   = (state == IDLE) & io.in_valid;
  assign last_bit = (state == SHIFT) & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.in_valid) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = (state == IDLE);
    io.out_valid = (state == DONE);
  end

  // Difference bits enter at the MSB so that after WIDTH shifts bit 0 sits at diff[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      diff_q <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= io.a;
      b_sr   <= io.b;
      borrow <= io.bin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      diff_q <= {cell_d, diff_q[WIDTH-1:1]};
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      borrow <= cell_bo;
      if (last_bit) bout_q <= cell_bo;
      else          cnt    <= cnt + 1'b1;
    end
  end

  assign io.diff = diff_q;
  assign io.bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // On the last shift edge cell_d is the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_msb <= io.a[WIDTH-1];
      b_msb <= io.b[WIDTH-1];
    end else if (last_bit) begin
      ovf_q <= (a_msb != b_msb) & (cell_d != a_msb);
    end
  end

  assign io.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;

  serial_subtractor_if #(.WIDTH(W)) io ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin,
                           output logic [W-1:0] d, output logic bo, output logic ov);
    int u;
    int s;
    u  = int'(ra) - int'(rb) - int'(rbin);
    s  = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
    d  = W'(u + (1 << W));
    bo = (u < 0);
    ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] ed, input logic eb, input logic eo);
    chk({tag, "_diff"}, 32'(io.diff), 32'(ed));
    chk({tag, "_bout"}, 32'(io.bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(io.ovf), 32'(eo));
`else
    if (eo === 1'bx) chk({tag, "_ovf_model"}, 32'(eo), 32'd0);
`endif
  endtask

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin, input int hold);
    logic [W-1:0] ed;
    logic eb;
    logic eo;
    int n;
    ref_model(oa, ob, obin, ed, eb, eo);
    io.out_ready = (hold == 0);
    chk("in_ready_idle", 32'(io.in_ready), 32'd1);
    io.a = oa;
    io.b = ob;
    io.bin = obin;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    io.a = W'($urandom);
    io.b = W'($urandom);
    io.bin = 1'($urandom);
    chk("in_ready_busy", 32'(io.in_ready), 32'd0);
    n = 0;
    while (!io.out_valid && n < 4 * W) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(W));
    chk_result("res", ed, eb, eo);
    for (int i = 0; i < hold; i++) begin
      io.in_valid = (i == 1);
      tick();
      chk("bp_out_valid", 32'(io.out_valid), 32'd1);
      chk("bp_in_ready", 32'(io.in_ready), 32'd0);
      chk_result("bp", ed, eb, eo);
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    tick();
    chk("ret_out_valid", 32'(io.out_valid), 32'd0);
    chk("ret_in_ready", 32'(io.in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] qd[$];
    logic         qb[$];
    logic         qo[$];
    logic [W-1:0] ta, tb, ed;
    logic         tbin, eb, eo;
    int           nres, last_t;

    io.in_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    io.bin = 1'b0;
    io.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk_result("rst", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    run_op(8'h5A, 8'h3C, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 0);
    run_op(8'h10, 8'h10, 1'b1, 0);
    run_op(8'hC3, 8'h2E, 1'b1, 5);

    // Reset three cycles into the shift phase.
    io.a = 8'hFF;
    io.b = 8'h00;
    io.bin = 1'b0;
    io.in_valid = 1'b1;
    io.out_ready = 1'b1;
    tick();
    io.in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("mid_rst_diff", 32'(io.diff), 32'd0);
    chk("mid_rst_bout", 32'(io.bout), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(8'hFF, 8'h0F, 1'b0, 0);

    // Back-to-back with in_valid and out_ready tied high.
    nres = 0;
    last_t = -1;
    io.out_ready = 1'b1;
    io.in_valid = 1'b1;
    for (int c = 0; c < 80 && nres < 3; c++) begin
      if (io.in_ready) begin
        ta = W'($urandom);
        tb = W'($urandom);
        tbin = 1'($urandom);
        io.a = ta;
        io.b = tb;
        io.bin = tbin;
        ref_model(ta, tb, tbin, ed, eb, eo);
        qd.push_back(ed);
        qb.push_back(eb);
        qo.push_back(eo);
      end
      tick();
      if (io.out_valid) begin
        if (qd.size() > 0) begin
          chk_result("b2b", qd.pop_front(), qb.pop_front(), qo.pop_front());
        end else begin
          chk("b2b_spurious", 32'd1, 32'd0);
        end
        if (last_t >= 0) chk("b2b_spacing", 32'(cycle - last_t), 32'(W + 2));
        last_t = cycle;
        nres++;
      end
    end
    io.in_valid = 1'b0;
    chk("b2b_count", 32'(nres), 32'd3);
    tick();

    repeat (12) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    run_op(8'h00, 8'hFF, 1'b1, 1);

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, 0);
    chk("ovf_80_01", 32'(io.ovf), 32'd1);
    run_op(8'h7F, 8'hFF, 1'b0, 0);
    chk("ovf_7f_ff", 32'(io.ovf), 32'd1);
    run_op(8'h05, 8'h03, 1'b0, 0);
    chk("ovf_05_03", 32'(io.ovf), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
